// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM.
// Owns the single shared memory port (fetch and lw/sw data take turns),
// drives the PC/IR/MDR/regfile enables and a retire pulse, and parks in a
// sticky FAULT state when memory stops answering.
module core_sequencer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       mem_read,
  input  logic       mem_write,
  input  logic       reg_write,
  input  logic       branch,
  input  logic       branch_ne,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_we,
  output logic       mdr_we,
  output logic       rf_we,
  output logic       pc_we,
  output logic       pc_src,
  output logic       retire,
  output logic       fault,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd7
  } state_t;

  // The counter only has to reach MEM_TIMEOUT-1 before FAULT is taken.
  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(MEM_TIMEOUT - 1);

  state_t        state, state_next;
  logic [CW-1:0] to_cnt;
  logic          taken;
  logic          timed_out;
  logic          enter_access;

  assign taken        = branch & (alu_zero ^ branch_ne);
  // mem_ready in the last allowed cycle still completes the access.
  assign timed_out    = (to_cnt == TO_LAST) && !mem_ready;
  assign enter_access = (state_next != state) &&
                        (state_next == S_FETCH || state_next == S_MEM);
  assign state_o      = state;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Memory wait counter: restarts on each new access, counts stalled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        to_cnt <= '0;
    else if (enter_access)          to_cnt <= '0;
    else if (mem_req && !mem_ready) to_cnt <= to_cnt + 1'b1;
  end

  // Next-state and output decode.
  always_comb begin
    // NOTE: every output gets a default first, so no path through the case
    // leaves a signal unassigned and no latch is inferred.
    state_next   = state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    mdr_we       = 1'b0;
    rf_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 1'b0;
    retire       = 1'b0;
    fault        = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (run) state_next = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we      = 1'b1;
          state_next = S_DECODE;
        end else if (timed_out) begin
          state_next = S_FAULT;
        end
      end
      S_DECODE: begin
        state_next = S_EXEC;
      end
      S_EXEC: begin
        if (branch) begin
          pc_we      = 1'b1;
          pc_src     = taken;
          retire     = 1'b1;
          state_next = S_IDLE;
        end else if (mem_read || mem_write) begin
          state_next = S_MEM;
        end else if (reg_write) begin
          state_next = S_WB;
        end else begin
          // nop / unsupported: just step the PC
          pc_we      = 1'b1;
          retire     = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        // a simultaneous read+write decodes as a load
        mem_we       = mem_write & ~mem_read;
        if (mem_ready) begin
          if (mem_read) begin
            mdr_we     = 1'b1;
            state_next = S_WB;
          end else begin
            pc_we      = 1'b1;
            retire     = 1'b1;
            state_next = S_IDLE;
          end
        end else if (timed_out) begin
          state_next = S_FAULT;
        end
      end
      S_WB: begin
        rf_we      = 1'b1;
        pc_we      = 1'b1;
        retire     = 1'b1;
        state_next = S_IDLE;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_next = S_FAULT;
      end
    endcase
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed self-checking bench for core_sequencer: ALU, lw, sw, branch, nop,
// timeout boundary, sticky fault and asynchronous reset mid-access.
module tb_core_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       run, mem_read, mem_write, reg_write, branch, branch_ne, alu_zero, mem_ready;
  logic       mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, rf_we, pc_we, pc_src, retire, fault;
  logic [2:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Output bit masks, ordered as in the observed vector below.
  localparam logic [9:0] NONE = 10'h000;
  localparam logic [9:0] REQ  = 10'h200;
  localparam logic [9:0] WE   = 10'h100;
  localparam logic [9:0] SEL  = 10'h080;
  localparam logic [9:0] IR   = 10'h040;
  localparam logic [9:0] MDR  = 10'h020;
  localparam logic [9:0] RF   = 10'h010;
  localparam logic [9:0] PCW  = 10'h008;
  localparam logic [9:0] PCS  = 10'h004;
  localparam logic [9:0] RET  = 10'h002;
  localparam logic [9:0] FLT  = 10'h001;

  core_sequencer #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .run(run),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .branch(branch), .branch_ne(branch_ne), .alu_zero(alu_zero),
    .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_we(ir_we), .mdr_we(mdr_we), .rf_we(rf_we), .pc_we(pc_we),
    .pc_src(pc_src), .retire(retire), .fault(fault), .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] observed();
    return {state_o, mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, rf_we,
            pc_we, pc_src, retire, fault};
  endfunction

  task automatic check(input string tag, input logic [2:0] st, input logic [9:0] outs);
    logic [12:0] obs, exp;
    obs = observed();
    exp = {st, outs};
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with this cycle's inputs applied: check, then advance.
  task automatic step(input string tag, input logic [2:0] st, input logic [9:0] outs);
    #1;
    check(tag, st, outs);
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctrl(input logic mr, mw, rw, br, ne, z);
    mem_read = mr; mem_write = mw; reg_write = rw;
    branch = br; branch_ne = ne; alu_zero = z;
  endtask

  // Instruction that retires in EXEC, zero wait states.
  task automatic run_short(input string tag, input logic [9:0] exec_outs);
    mem_ready = 1'b1; run = 1'b1;
    step({tag, "_idle"}, 3'd0, NONE);
    run = 1'b0;
    step({tag, "_fetch"}, 3'd1, REQ | IR);
    step({tag, "_decode"}, 3'd2, NONE);
    step({tag, "_exec"}, 3'd3, exec_outs);
    step({tag, "_after"}, 3'd0, NONE);
  endtask

  initial begin
    rst = 1'b1; run = 1'b1; mem_ready = 1'b1;
    set_ctrl(0, 0, 1, 0, 0, 0);
    #3;
    check("reset_state", 3'd0, NONE);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1. ALU op, back-to-back with a 5-cycle period, then run dropped mid-instruction
    step("alu_idle",   3'd0, NONE);
    step("alu_fetch",  3'd1, REQ | IR);
    step("alu_decode", 3'd2, NONE);
    step("alu_exec",   3'd3, NONE);
    step("alu_wb",     3'd5, RF | PCW | RET);
    step("alu_idle2",  3'd0, NONE);
    step("alu2_fetch", 3'd1, REQ | IR);
    run = 1'b0;
    step("alu2_decode", 3'd2, NONE);
    step("alu2_exec",   3'd3, NONE);
    step("alu2_wb",     3'd5, RF | PCW | RET);
    step("alu2_hold0",  3'd0, NONE);
    step("alu2_hold1",  3'd0, NONE);

    // 2. lw: fetch 3 waits, mem 2 waits; retire in cycle 11 counting the IDLE cycle
    set_ctrl(1, 0, 1, 0, 0, 0);
    mem_ready = 1'b0; run = 1'b1;
    step("lw_idle", 3'd0, NONE);
    run = 1'b0;
    step("lw_fetch_w0", 3'd1, REQ);
    step("lw_fetch_w1", 3'd1, REQ);
    step("lw_fetch_w2", 3'd1, REQ);
    mem_ready = 1'b1;
    step("lw_fetch_rdy", 3'd1, REQ | IR);
    mem_ready = 1'b0;
    step("lw_decode", 3'd2, NONE);
    step("lw_exec",   3'd3, NONE);
    step("lw_mem_w0", 3'd4, REQ | SEL);
    step("lw_mem_w1", 3'd4, REQ | SEL);
    mem_ready = 1'b1;
    step("lw_mem_rdy", 3'd4, REQ | SEL | MDR);
    step("lw_wb",      3'd5, RF | PCW | RET);
    step("lw_after",   3'd0, NONE);

    // 3. sw: write access, retires in MEM, no rf_we
    set_ctrl(0, 1, 0, 0, 0, 0);
    run = 1'b1;
    step("sw_idle", 3'd0, NONE);
    run = 1'b0;
    step("sw_fetch",  3'd1, REQ | IR);
    step("sw_decode", 3'd2, NONE);
    step("sw_exec",   3'd3, NONE);
    step("sw_mem",    3'd4, REQ | WE | SEL | PCW | RET);
    step("sw_after",  3'd0, NONE);

    // 4. branches, priority over memory/reg_write, nop, read+write as load
    set_ctrl(0, 0, 0, 1, 0, 1);
    run_short("beq_taken", PCW | PCS | RET);
    set_ctrl(0, 0, 0, 1, 1, 1);
    run_short("bne_not_taken", PCW | RET);
    set_ctrl(0, 0, 0, 1, 1, 0);
    run_short("bne_taken", PCW | PCS | RET);
    set_ctrl(1, 0, 1, 1, 0, 0);
    run_short("br_priority", PCW | RET);
    set_ctrl(0, 0, 0, 0, 0, 0);
    run_short("nop", PCW | RET);

    set_ctrl(1, 1, 0, 0, 0, 0);
    run = 1'b1;
    step("rw_idle", 3'd0, NONE);
    run = 1'b0;
    step("rw_fetch",  3'd1, REQ | IR);
    step("rw_decode", 3'd2, NONE);
    step("rw_exec",   3'd3, NONE);
    step("rw_mem",    3'd4, REQ | SEL | MDR);
    step("rw_wb",     3'd5, RF | PCW | RET);

    // 5a. ready in the 16th request cycle wins over the timeout
    set_ctrl(0, 0, 0, 0, 0, 0);
    mem_ready = 1'b0; run = 1'b1;
    step("edge_idle", 3'd0, NONE);
    run = 1'b0;
    for (int i = 0; i < 15; i++) step($sformatf("edge_fetch_w%0d", i), 3'd1, REQ);
    mem_ready = 1'b1;
    step("edge_fetch_rdy", 3'd1, REQ | IR);
    step("edge_decode",    3'd2, NONE);
    step("edge_exec",      3'd3, PCW | RET);

    // 5b. no answer for 16 request cycles -> sticky FAULT, cleared only by rst
    mem_ready = 1'b0; run = 1'b1;
    step("to_idle", 3'd0, NONE);
    run = 1'b0;
    for (int i = 0; i < 16; i++) step($sformatf("to_fetch_w%0d", i), 3'd1, REQ);
    step("to_fault", 3'd7, FLT);
    run = 1'b1; mem_ready = 1'b1;
    step("to_fault_hold0", 3'd7, FLT);
    step("to_fault_hold1", 3'd7, FLT);
    rst = 1'b1;
    #1;
    check("to_async_rst", 3'd0, NONE);
    @(posedge clk); #1;
    rst = 1'b0; run = 1'b0;
    step("to_post_rst", 3'd0, NONE);
    step("to_post_rst_hold", 3'd0, NONE);

    // 6. async reset in the middle of a stalled store
    set_ctrl(0, 1, 0, 0, 0, 0);
    mem_ready = 1'b1; run = 1'b1;
    step("rstm_idle", 3'd0, NONE);
    run = 1'b0; mem_ready = 1'b0;
    // fetch completes on its first cycle
    mem_ready = 1'b1;
    step("rstm_fetch", 3'd1, REQ | IR);
    mem_ready = 1'b0;
    step("rstm_decode", 3'd2, NONE);
    step("rstm_exec",   3'd3, NONE);
    step("rstm_mem_w0", 3'd4, REQ | WE | SEL);
    #1;
    rst = 1'b1;
    #1;
    check("rstm_async", 3'd0, NONE);
    #1;
    rst = 1'b0; run = 1'b1; mem_ready = 1'b1;
    #1;
    check("rstm_released", 3'd0, NONE);
    @(posedge clk); #1;
    run = 1'b0;
    step("rstm_next_fetch", 3'd1, REQ | WE & 10'h000 | IR);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
